// File: rtl/clock_pkg.sv
// clock_pkg: shared encodings for the digital clock blocks (mode sequencer,
// time counter, display mux).
//   MODE_*      2-bit mode codes as seen on the mode bus
//   clk_state_t sequencer state; values equal the mode codes so that the
//               state register drives the mode bus directly
package clock_pkg;

    localparam logic [1:0] MODE_RUN      = 2'b00;
    localparam logic [1:0] MODE_SET_MIN  = 2'b01;
    localparam logic [1:0] MODE_SET_HOUR = 2'b10;
    localparam logic [1:0] MODE_SET_SEC  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN      = MODE_RUN,
        ST_SET_MIN  = MODE_SET_MIN,
        ST_SET_HOUR = MODE_SET_HOUR,
        ST_SET_SEC  = MODE_SET_SEC
    } clk_state_t;

endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: front-panel / counter-side signal bundle of the mode
// sequencer.
//   tick_1hz, key_mode, key_sel, key_inc   panel side -> sequencer
//   mode, hold, inc_min, inc_hour, clr_sec, blink   sequencer -> counter/display
// master = panel/counter environment, slave = time_set_ctrl.
interface time_set_ctrl_if;
    logic       tick_1hz;
    logic       key_mode;
    logic       key_sel;
    logic       key_inc;
    logic [1:0] mode;
    logic       hold;
    logic       inc_min;
    logic       inc_hour;
    logic       clr_sec;
    logic       blink;

    modport master (
        output tick_1hz, key_mode, key_sel, key_inc,
        input  mode, hold, inc_min, inc_hour, clr_sec, blink
    );

    modport slave (
        input  tick_1hz, key_mode, key_sel, key_inc,
        output mode, hold, inc_min, inc_hour, clr_sec, blink
    );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronizes one raw active-low key and emits a one-cycle
// press pulse when the debounced level falls.
//   clk    system clock
//   rst    async active-high reset (key treated as released)
//   key_n  raw key, active-low, asynchronous
//   press  one-cycle pulse on debounced 1->0
// Latency: raw falling edge -> press high after DEB_CYCLES+2 edges, so the
// consumer acts on it at edge DEB_CYCLES+3.
module key_debounce #(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1, s2, deb;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            deb   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                // DEB_CYCLES consecutive differing samples: accept new level.
                deb   <= s2;
                cnt   <= '0;
                press <= ~s2;   // only a fall (new level 0) is an event
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: RUN/SET mode sequencer for the clock timekeeping datapath.
//   clk, rst   system clock, async active-high reset
//   bus        time_set_ctrl_if.slave: raw keys + 1 Hz tick in; mode, hold,
//              inc_min/inc_hour/clr_sec strobes and field blink out
// One action per cycle, priority mode > sel > inc > timeout.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES = 20,
    parameter int TIMEOUT_S  = 30
) (
    input logic            clk,
    input logic            rst,
    time_set_ctrl_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    logic p_mode, p_sel, p_inc;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (.clk(clk), .rst(rst), .key_n(bus.key_mode), .press(p_mode));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel  (.clk(clk), .rst(rst), .key_n(bus.key_sel),  .press(p_sel));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc  (.clk(clk), .rst(rst), .key_n(bus.key_inc),  .press(p_inc));

    clk_state_t    state, state_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          blink_q, blink_nxt;
    logic          inc_min_q, inc_hour_q, clr_sec_q;
    logic          inc_min_nxt, inc_hour_nxt, clr_sec_nxt;
    logic          in_set;

    assign in_set = (state != ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            tcnt       <= '0;
            blink_q    <= 1'b0;
            inc_min_q  <= 1'b0;
            inc_hour_q <= 1'b0;
            clr_sec_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            tcnt       <= tcnt_nxt;
            blink_q    <= blink_nxt;
            inc_min_q  <= inc_min_nxt;
            inc_hour_q <= inc_hour_nxt;
            clr_sec_q  <= clr_sec_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tcnt_nxt     = tcnt;
        blink_nxt    = blink_q;
        inc_min_nxt  = 1'b0;
        inc_hour_nxt = 1'b0;
        clr_sec_nxt  = 1'b0;

        if (p_mode) begin
            state_nxt = in_set ? ST_RUN : ST_SET_MIN;
        end else if (p_sel) begin
            case (state)
                ST_SET_MIN:  state_nxt = ST_SET_HOUR;
                ST_SET_HOUR: state_nxt = ST_SET_SEC;
                ST_SET_SEC:  state_nxt = ST_SET_MIN;
                default:     state_nxt = state;
            endcase
        end else if (p_inc) begin
            case (state)
                ST_SET_MIN:  inc_min_nxt  = 1'b1;
                ST_SET_HOUR: inc_hour_nxt = 1'b1;
                ST_SET_SEC:  clr_sec_nxt  = 1'b1;
                default:     ;
            endcase
        end else if (in_set && bus.tick_1hz && tcnt == TW'(TIMEOUT_S - 1)) begin
            // The tick that would bring the count to TIMEOUT_S exits
            // directly, so mode is RUN on the cycle right after that tick.
            state_nxt = ST_RUN;
        end

        // Any press (even an ignored one) restarts the inactivity window.
        if (p_mode || p_sel || p_inc || state_nxt != state || !in_set)
            tcnt_nxt = '0;
        else if (bus.tick_1hz)
            tcnt_nxt = tcnt + 1'b1;

        if (state_nxt != state || !in_set)
            blink_nxt = 1'b0;
        else if (bus.tick_1hz)
            blink_nxt = ~blink_q;
    end

    assign bus.mode     = state;
    assign bus.hold     = in_set;
    assign bus.blink    = blink_q;
    assign bus.inc_min  = inc_min_q;
    assign bus.inc_hour = inc_hour_q;
    assign bus.clr_sec  = clr_sec_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed bench for time_set_ctrl (DEB_CYCLES=4,
// TIMEOUT_S=3). Strobes are counted on the falling edge; checks sample
// 1 time unit after the rising edge.
module tb_time_set_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ntest = 0;
    int   nfail = 0;
    int   n_min = 0, n_hour = 0, n_sec = 0, n_multi = 0;
    int   b_min, b_hour, b_sec;

    always #5 clk = ~clk;

    time_set_ctrl_if bus ();

    time_set_ctrl #(.DEB_CYCLES(4), .TIMEOUT_S(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        n_min  += int'(bus.inc_min);
        n_hour += int'(bus.inc_hour);
        n_sec  += int'(bus.clr_sec);
        if (int'(bus.inc_min) + int'(bus.inc_hour) + int'(bus.clr_sec) > 1) n_multi++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        ntest++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0:       bus.key_mode = v;
            1:       bus.key_sel  = v;
            default: bus.key_inc  = v;
        endcase
    endtask

    // Press key k for len cycles, then let the release settle.
    task automatic press(input int k, input int len);
        @(negedge clk);
        set_key(k, 1'b0);
        repeat (len) @(negedge clk);
        set_key(k, 1'b1);
        repeat (15) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        bus.tick_1hz = 1'b1;
        @(posedge clk);
        #1 bus.tick_1hz = 1'b0;
    endtask

    task automatic snap();
        b_min = n_min; b_hour = n_hour; b_sec = n_sec;
    endtask

    initial begin
        bus.tick_1hz = 1'b0;
        bus.key_mode = 1'b1;
        bus.key_sel  = 1'b1;
        bus.key_inc  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode",  int'(bus.mode), 0);
        chk("rst_hold",  int'(bus.hold), 0);
        chk("rst_blink", int'(bus.blink), 0);
        chk("rst_strb",  int'(bus.inc_min) + int'(bus.inc_hour) + int'(bus.clr_sec), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: mode press latency, single transition
        bus.key_mode = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("t1_edge6_mode", int'(bus.mode), 0);
        @(posedge clk);
        #1 chk("t1_edge7_mode", int'(bus.mode), 1);
        chk("t1_edge7_hold", int'(bus.hold), 1);
        repeat (13) @(negedge clk);
        bus.key_mode = 1'b1;
        repeat (15) @(negedge clk);
        chk("t1_once", int'(bus.mode), 1);

        // 2: glitch rejected, long press gives one strobe
        snap();
        @(negedge clk);
        bus.key_inc = 1'b0;
        repeat (3) @(negedge clk);
        bus.key_inc = 1'b1;
        repeat (15) @(negedge clk);
        chk("t2_glitch", n_min - b_min, 0);
        press(2, 10);
        chk("t2_inc_min", n_min - b_min, 1);
        chk("t2_mode", int'(bus.mode), 1);

        // 3: field cycling and per-field strobes
        press(1, 10);
        chk("t3_sel1", int'(bus.mode), 2);
        snap();
        press(2, 10);
        chk("t3_inc_hour", n_hour - b_hour, 1);
        chk("t3_no_min", n_min - b_min, 0);
        press(1, 10);
        chk("t3_sel2", int'(bus.mode), 3);
        snap();
        press(2, 10);
        chk("t3_clr_sec", n_sec - b_sec, 1);
        chk("t3_no_hour", n_hour - b_hour, 0);
        press(1, 10);
        chk("t3_sel3", int'(bus.mode), 1);
        chk("t3_hold", int'(bus.hold), 1);

        // 4: timeout from SET_HOUR
        press(1, 10);
        chk("t4_in_hour", int'(bus.mode), 2);
        tick();
        chk("t4_blink1", int'(bus.blink), 1);
        repeat (3) @(negedge clk);
        tick();
        chk("t4_blink2", int'(bus.blink), 0);
        chk("t4_pre_mode", int'(bus.mode), 2);
        repeat (3) @(negedge clk);
        tick();
        chk("t4_to_mode", int'(bus.mode), 0);
        chk("t4_to_hold", int'(bus.hold), 0);
        chk("t4_to_blink", int'(bus.blink), 0);

        // 4b: press on the third-tick cycle cancels the timeout
        press(0, 10);
        press(1, 10);
        chk("t4b_in_hour", int'(bus.mode), 2);
        tick();
        repeat (3) @(negedge clk);
        tick();
        snap();
        @(negedge clk);
        bus.key_inc = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        bus.tick_1hz = 1'b1;
        @(posedge clk);
        #1 bus.tick_1hz = 1'b0;
        chk("t4b_no_to", int'(bus.mode), 2);
        repeat (4) @(negedge clk);
        bus.key_inc = 1'b1;
        repeat (15) @(negedge clk);
        chk("t4b_inc_hour", n_hour - b_hour, 1);
        tick();
        chk("t4b_restart", int'(bus.mode), 2);

        // 5: mode and inc land together in SET_MIN
        press(1, 10);
        press(1, 10);
        chk("t5_in_min", int'(bus.mode), 1);
        snap();
        @(negedge clk);
        bus.key_mode = 1'b0;
        bus.key_inc  = 1'b0;
        repeat (10) @(negedge clk);
        bus.key_mode = 1'b1;
        bus.key_inc  = 1'b1;
        repeat (15) @(negedge clk);
        chk("t5_mode", int'(bus.mode), 0);
        chk("t5_no_min", n_min - b_min, 0);

        // 6: async reset in SET_SEC with blink on; held key after release
        press(0, 10);
        press(1, 10);
        press(1, 10);
        chk("t6_in_sec", int'(bus.mode), 3);
        tick();
        chk("t6_blink", int'(bus.blink), 1);
        @(negedge clk);
        bus.key_mode = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_mode",  int'(bus.mode), 0);
        chk("t6_rst_hold",  int'(bus.hold), 0);
        chk("t6_rst_blink", int'(bus.blink), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("t6_edge6_mode", int'(bus.mode), 0);
        @(posedge clk);
        #1 chk("t6_edge7_mode", int'(bus.mode), 1);
        repeat (15) @(negedge clk);
        bus.key_mode = 1'b1;
        repeat (15) @(negedge clk);
        chk("t6_once", int'(bus.mode), 1);

        chk("onehot_strobes", n_multi, 0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
